reg_commit_ctrl: RTL and testbench

Write-port scheduler and rename-recovery sequencer for the register file. It sits between the ROB commit interface and the register file. Commits are buffered in a small queue and retired one per cycle onto the register-file write port. A committed write clears a register's rename tag only when that tag still belongs to the committing ROB entry, and decoder rename updates take priority in the same cycle. On a flush it drains already-committed writes, then clears all rename state in one cycle.

---
 rtl/reg_commit_ctrl_pkg.sv | 9 +
 rtl/reg_commit_ctrl_fifo.sv | 38 +++
 rtl/reg_commit_ctrl.sv | 98 +++++++++
 tb/tb_reg_commit_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_commit_ctrl_pkg.sv
// reg_commit_ctrl_pkg: shared widths, constants and FSM encoding for the commit controller
package reg_commit_ctrl_pkg;
   localparam int REG_IDX_W = 5;
   localparam int ROB_TAG_W = 4;
   localparam logic [ROB_TAG_W-1:0] ROBNOTRENAME = '0;
   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;
endpackage

// File: rtl/reg_commit_ctrl_fifo.sv
// commit_fifo: circular buffer of committed writes with push/pop/full/empty/count
module commit_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   // pointers wrap naturally at DEPTH since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   // storage needs no reset; the count guards every read
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end
   assign dout  = mem[rp];
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/reg_commit_ctrl.sv
// reg_commit_ctrl: commit queue to register-file write port with rename-recovery sequencing
// Optional REG_COMMIT_BYPASS_EN: an accepted commit into an empty queue writes in the same cycle.
module reg_commit_ctrl
   import reg_commit_ctrl_pkg::*;
#(
   parameter int QDEPTH = 4,
   parameter int ROB_W  = ROB_TAG_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 cm_valid,
   output logic                 cm_ready,
   input  logic [REG_IDX_W-1:0] cm_index,
   input  logic [ROB_W-1:0]     cm_rename,
   input  logic [31:0]          cm_value,
   input  logic                 flush,
   input  logic                 dec_rd_valid,
   input  logic [REG_IDX_W-1:0] dec_rd_index,
   input  logic [ROB_W-1:0]     dec_rd_rename,
   output logic                 dec_stall,
   input  logic [ROB_W-1:0]     rf_cur_rename,
   input  logic                 rf_cur_renamed,
   output logic                 rf_we,
   output logic [REG_IDX_W-1:0] rf_waddr,
   output logic [31:0]          rf_wdata,
   output logic                 rf_clr_rename,
   output logic                 rf_set_valid,
   output logic [REG_IDX_W-1:0] rf_set_index,
   output logic [ROB_W-1:0]     rf_set_rename,
   output logic                 rf_clr_all
);
   localparam int QAW = $clog2(QDEPTH);
   localparam int EW  = REG_IDX_W + ROB_W + 32;
   state_t               state, state_nx;
   logic                 full, empty, popping, hs, byp, push, wr_act;
   logic [QAW:0]         count, cnt_nx;
   logic [EW-1:0]        head;
   logic [REG_IDX_W-1:0] w_idx;
   logic [ROB_W-1:0]     w_tag;
   logic [31:0]          w_val;

   commit_fifo #(.DEPTH(QDEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (popping),
      .din   ({cm_index, cm_rename, cm_value}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign popping = rdy & !empty;
   assign hs      = cm_valid & cm_ready;
`ifdef REG_COMMIT_BYPASS_EN
   assign byp = (hs & empty) ? TRUE : FALSE;
`else
   assign byp = FALSE;
`endif
   assign push   = hs & !byp;
   assign wr_act = popping | byp;
   assign cnt_nx = count + (QAW+1)'(push) - (QAW+1)'(popping);
   assign {w_idx, w_tag, w_val} = popping ? head : {cm_index, cm_rename, cm_value};

   assign rf_we         = wr_act & (w_idx != '0);
   assign rf_waddr      = wr_act ? w_idx : '0;
   assign rf_wdata      = wr_act ? w_val : '0;
   assign rf_set_valid  = rdy & dec_rd_valid & !dec_stall & (dec_rd_index != '0);
   assign rf_set_index  = rf_set_valid ? dec_rd_index : '0;
   assign rf_set_rename = rf_set_valid ? dec_rd_rename : ROBNOTRENAME;
   assign rf_clr_rename = rf_we & rf_cur_renamed & (rf_cur_rename == w_tag)
                          & !(rf_set_valid & (dec_rd_index == w_idx));

   // state register; frozen while rdy is low
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else if (rdy) state <= state_nx;
   end

   // flush drains queued writes before the single-cycle clear
   always_comb begin
      state_nx = state;
      unique case (state)
         RUN:     if (flush) state_nx = (cnt_nx == '0) ? CLEAR : DRAIN;
         DRAIN:   if (cnt_nx == '0) state_nx = CLEAR;
         default: state_nx = RUN;
      endcase
   end

   // state-dependent handshake, stall and clear outputs
   always_comb begin
      cm_ready   = rdy & (state == RUN) & (!full | popping);
      dec_stall  = flush | (state != RUN);
      rf_clr_all = rdy & (state == CLEAR);
   end
endmodule

// File: tb/tb_reg_commit_ctrl.sv
// tb_reg_commit_ctrl: directed plus randomized checks against a queue-based reference model
module tb_reg_commit_ctrl;
   localparam int QDEPTH = 4;
   localparam int ROB_W  = 4;

   logic              clk = 1'b0;
   logic              rst, rdy, cm_valid, flush, dec_rd_valid, rf_cur_renamed;
   logic [4:0]        cm_index, dec_rd_index;
   logic [ROB_W-1:0]  cm_rename, dec_rd_rename, rf_cur_rename;
   logic [31:0]       cm_value;
   logic              cm_ready, dec_stall, rf_we, rf_clr_rename, rf_set_valid, rf_clr_all;
   logic [4:0]        rf_waddr, rf_set_index;
   logic [31:0]       rf_wdata;
   logic [ROB_W-1:0]  rf_set_rename;

   always #5 clk = ~clk;

   reg_commit_ctrl #(.QDEPTH(QDEPTH), .ROB_W(ROB_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_index(cm_index),
      .cm_rename(cm_rename), .cm_value(cm_value), .flush(flush),
      .dec_rd_valid(dec_rd_valid), .dec_rd_index(dec_rd_index),
      .dec_rd_rename(dec_rd_rename), .dec_stall(dec_stall),
      .rf_cur_rename(rf_cur_rename), .rf_cur_renamed(rf_cur_renamed),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_clr_rename(rf_clr_rename), .rf_set_valid(rf_set_valid),
      .rf_set_index(rf_set_index), .rf_set_rename(rf_set_rename),
      .rf_clr_all(rf_clr_all)
   );

   typedef struct {
      logic [4:0]       idx;
      logic [ROB_W-1:0] tag;
      logic [31:0]      val;
   } ent_t;

   int   n_chk = 0;
   int   n_pass = 0;
   ent_t q[$];
   int   mode = 0;
   logic m_pop, m_hs, m_byp;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // expected outputs from the queue contents and drain/clear phase
   task automatic model_check;
      ent_t w;
      logic act, e_we, e_setv, e_clr, e_ready, e_stall;
      m_pop   = rdy && q.size() > 0;
      e_ready = rdy && mode == 0 && (q.size() < QDEPTH || m_pop);
      e_stall = flush || mode != 0;
      m_hs    = cm_valid && e_ready;
      m_byp   = 1'b0;
`ifdef REG_COMMIT_BYPASS_EN
      m_byp   = m_hs && q.size() == 0;
`endif
      act = m_pop || m_byp;
      if (m_pop) w = q[0];
      else w = '{cm_index, cm_rename, cm_value};
      e_we   = act && w.idx != 0;
      e_setv = rdy && dec_rd_valid && !e_stall && dec_rd_index != 0;
      e_clr  = e_we && rf_cur_renamed && rf_cur_rename == w.tag && !(e_setv && dec_rd_index == w.idx);
      chk("cm_ready", cm_ready, e_ready);
      chk("dec_stall", dec_stall, e_stall);
      chk("rf_we", rf_we, e_we);
      chk("rf_waddr", rf_waddr, act ? w.idx : 5'd0);
      chk("rf_wdata", rf_wdata, act ? w.val : 32'd0);
      chk("rf_clr_rename", rf_clr_rename, e_clr);
      chk("rf_set_valid", rf_set_valid, e_setv);
      chk("rf_set_index", rf_set_index, e_setv ? dec_rd_index : 5'd0);
      chk("rf_set_rename", rf_set_rename, e_setv ? dec_rd_rename : '0);
      chk("rf_clr_all", rf_clr_all, rdy && mode == 2);
   endtask

   task automatic model_update;
      if (rst) begin
         q.delete();
         mode = 0;
      end else if (rdy) begin
         if (m_pop) void'(q.pop_front());
         if (m_hs && !m_byp) q.push_back('{cm_index, cm_rename, cm_value});
         if (mode == 0) begin
            if (flush) mode = (q.size() == 0) ? 2 : 1;
         end else if (mode == 1) begin
            if (q.size() == 0) mode = 2;
         end else mode = 0;
      end
   endtask

   task automatic cycle;
      #1;
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle;
      rst = 0; rdy = 1; cm_valid = 0; flush = 0; dec_rd_valid = 0;
      cm_index = 0; cm_rename = 0; cm_value = 0;
      dec_rd_index = 0; dec_rd_rename = 0;
      rf_cur_rename = 0; rf_cur_renamed = 0;
   endtask

   task automatic commit(input logic [4:0] i, input logic [ROB_W-1:0] t, input logic [31:0] v);
      cm_valid = 1; cm_index = i; cm_rename = t; cm_value = v;
   endtask

   initial begin
      int stall_n, clra_n;
      idle();
      rst = 1;
      @(posedge clk);
      @(posedge clk);
      model_update();
      @(negedge clk);
      idle();
      #1;
      chk("rst_cm_ready", cm_ready, 1'b1);
      chk("rst_dec_stall", dec_stall, 1'b0);
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_rf_clr_all", rf_clr_all, 1'b0);
      cycle();
      // basic commit with matching tag clears the rename
      commit(5, 3, 32'hDEADBEEF);
      cycle();
      idle(); rf_cur_rename = 3; rf_cur_renamed = 1;
      #1;
      chk("t1_we", rf_we, 1'b1);
      chk("t1_waddr", rf_waddr, 5'd5);
      chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
      chk("t1_clr", rf_clr_rename, 1'b1);
      cycle();
      // stale tag: write happens, no clear
      commit(5, 3, 32'h0BADF00D);
      cycle();
      idle(); rf_cur_rename = 7; rf_cur_renamed = 1;
      #1;
      chk("t2_we", rf_we, 1'b1);
      chk("t2_clr", rf_clr_rename, 1'b0);
      cycle();
      // decoder rename on the same index wins over the clear
      commit(8, 1, 32'h88);
      cycle();
      idle(); rf_cur_rename = 1; rf_cur_renamed = 1;
      dec_rd_valid = 1; dec_rd_index = 8; dec_rd_rename = 9;
      #1;
      chk("t3_we", rf_we, 1'b1);
      chk("t3_setv", rf_set_valid, 1'b1);
      chk("t3_setr", rf_set_rename, 4'd9);
      chk("t3_clr", rf_clr_rename, 1'b0);
      cycle();
      // back-to-back commits, flush with the fourth
      idle();
      stall_n = 0; clra_n = 0;
      for (int i = 0; i < 4; i++) begin
         commit(5'(i + 1), 4'(i), 32'(i));
         flush = (i == 3);
         #1;
         if (i == 3) stall_n += int'(dec_stall);
         cycle();
      end
      idle();
      for (int j = 0; j < 6; j++) begin
         #1;
         if (j == 0) chk("drain_ready", cm_ready, 1'b0);
         stall_n += int'(dec_stall);
         clra_n  += int'(rf_clr_all);
         cycle();
      end
      chk("flush_stall_cycles", stall_n, 3);
      chk("flush_clr_all_cycles", clra_n, 1);
      // rdy low blocks acceptance, then five commits flow in order
      for (int i = 0; i < 5; i++) begin
         commit(5'(20 + i), 0, 32'(i));
         rdy = 0;
         #1;
         chk("rdy0_ready", cm_ready, 1'b0);
         chk("rdy0_we", rf_we, 1'b0);
         cycle();
      end
      idle();
      for (int i = 0; i < 5; i++) begin
         commit(5'(10 + i), 4'(i), 32'(100 + i));
         #1;
         if (i > 0) chk("order", rf_waddr, 5'(10 + i - 1));
         cycle();
      end
      idle();
      #1;
      chk("order", rf_waddr, 5'd14);
      cycle();
      // write to x0 is dropped
      commit(0, 2, 32'h1234);
      cycle();
      idle(); rf_cur_rename = 2; rf_cur_renamed = 1;
      #1;
      chk("x0_we", rf_we, 1'b0);
      chk("x0_clr", rf_clr_rename, 1'b0);
      cycle();
      // reset in the middle of a drain
      commit(3, 1, 32'h33);
      flush = 1;
      cycle();
      idle();
      rst = 1;
      #1;
      chk("drain_state", dec_stall, 1'b1);
      cycle();
      idle();
      #1;
      chk("mrst_ready", cm_ready, 1'b1);
      chk("mrst_stall", dec_stall, 1'b0);
      chk("mrst_we", rf_we, 1'b0);
      chk("mrst_waddr", rf_waddr, 5'd0);
      chk("mrst_wdata", rf_wdata, 32'd0);
      chk("mrst_clr_all", rf_clr_all, 1'b0);
      cycle();
      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         logic [ROB_W-1:0] wt;
         rst          = ($urandom_range(0, 99) == 0);
         rdy          = ($urandom_range(0, 99) < 85);
         flush        = ($urandom_range(0, 99) < 5);
         cm_valid     = ($urandom_range(0, 99) < 70);
         cm_index     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         cm_rename    = ROB_W'($urandom);
         cm_value     = $urandom;
         dec_rd_valid = $urandom_range(0, 1) == 1;
         dec_rd_rename = ROB_W'($urandom);
         wt = (q.size() > 0) ? q[0].tag : cm_rename;
         dec_rd_index = (q.size() > 0 && $urandom_range(0, 2) == 0) ? q[0].idx : 5'($urandom);
         rf_cur_rename  = ($urandom_range(0, 1) == 1) ? wt : ROB_W'($urandom);
         rf_cur_renamed = ($urandom_range(0, 3) != 0);
         cycle();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
